// File: rtl/dirty_flush_ctrl_pkg.sv
// dirty_flush_ctrl_pkg: shared set-index width and flush FSM state encoding
package dirty_flush_ctrl_pkg;
    localparam int INDEX_W_DEF = 8;
    typedef enum logic [2:0] {
        FLUSH_IDLE, FLUSH_READ, FLUSH_CHECK, FLUSH_WB, FLUSH_CLEAR, FLUSH_DONE
    } flush_state_t;
endpackage

// File: rtl/dirty_flush_ctrl.sv
// dirty_flush_ctrl: dirty-bit register-file arbiter and flush sequencer
//   clk, resetn                       clock, async active-low reset
//   flush_req/flush_busy/flush_done   flush control and status
//   cache_addr/din/we/dout            pipeline port, forwarded only while idle
//   dr_addr/din/we/dout               dirty register-file master port
//   wb_valid/wb_index/wb_ready        write-back request handshake
module dirty_flush_ctrl
    import dirty_flush_ctrl_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done,
    input  logic [INDEX_W-1:0] cache_addr,
    input  logic               cache_din,
    input  logic               cache_we,
    output logic               cache_dout,
    output logic [INDEX_W-1:0] dr_addr,
    output logic               dr_din,
    output logic               dr_we,
    input  logic               dr_dout,
    output logic               wb_valid,
    output logic [INDEX_W-1:0] wb_index,
    input  logic               wb_ready
);
    flush_state_t state, state_n;
    logic [INDEX_W-1:0] idx, idx_n;
    logic idle, last;

    assign idle       = state == FLUSH_IDLE;
    assign last       = &idx;
    assign flush_busy = !idle;
    assign flush_done = state == FLUSH_DONE;
    assign cache_dout = idle ? dr_dout : 1'b0;
    assign dr_addr    = idle ? cache_addr : idx;
    assign dr_din     = idle ? cache_din : 1'b0;
    assign dr_we      = idle ? cache_we : state == FLUSH_CLEAR;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            FLUSH_IDLE: if (flush_req) begin
                state_n = FLUSH_READ;
                idx_n   = '0;
            end
            FLUSH_READ:  state_n = FLUSH_CHECK;
            FLUSH_CHECK: if (dr_dout) state_n = FLUSH_WB;
                else if (last) state_n = FLUSH_DONE;
                else begin
                    state_n = FLUSH_READ;
                    idx_n   = idx + 1'b1;
                end
            FLUSH_WB:    if (wb_valid && wb_ready) state_n = FLUSH_CLEAR;
            FLUSH_CLEAR: if (last) state_n = FLUSH_DONE;
                else begin
                    state_n = FLUSH_READ;
                    idx_n   = idx + 1'b1;
                end
            default:     state_n = FLUSH_IDLE;
        endcase
    end

    // wb_valid is a flop mirroring "next state is WB", so it is glitch-free
    // and stays high until the cycle after the handshake edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= FLUSH_IDLE;
            idx      <= '0;
            wb_valid <= 1'b0;
            wb_index <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            wb_valid <= state_n == FLUSH_WB;
            if (state == FLUSH_CHECK && dr_dout) wb_index <= idx;
        end
    end
endmodule

// File: tb/tb_dirty_flush_ctrl.sv
// tb_dirty_flush_ctrl: directed self-checking bench for dirty_flush_ctrl
module tb_dirty_flush_ctrl;
    import dirty_flush_ctrl_pkg::*;

    logic       clk = 0;
    logic       resetn = 0;
    logic       flush_req = 0;
    logic       flush_busy, flush_done;
    logic [7:0] cache_addr = '0;
    logic       cache_din = 0;
    logic       cache_we = 0;
    logic       cache_dout;
    logic [7:0] dr_addr;
    logic       dr_din, dr_we;
    logic       dr_dout;
    logic       wb_valid;
    logic [7:0] wb_index;
    logic       wb_ready = 1;

    int errors = 0;
    int checks = 0;

    dirty_flush_ctrl #(.INDEX_W(8)) dut (
        .clk(clk), .resetn(resetn), .flush_req(flush_req),
        .flush_busy(flush_busy), .flush_done(flush_done),
        .cache_addr(cache_addr), .cache_din(cache_din), .cache_we(cache_we),
        .cache_dout(cache_dout), .dr_addr(dr_addr), .dr_din(dr_din),
        .dr_we(dr_we), .dr_dout(dr_dout), .wb_valid(wb_valid),
        .wb_index(wb_index), .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;

    // dirty register file: registered read, write-through on write
    logic mem [256];
    always @(posedge clk) begin
        if (dr_we) mem[dr_addr] <= dr_din;
        dr_dout <= dr_we ? dr_din : mem[dr_addr];
    end

    // write-back responder log
    int         hs_n = 0;
    logic [7:0] hs_idx [64];
    int         wbv_cyc = 0;
    always @(posedge clk) begin
        if (wb_valid && wb_ready) begin
            hs_idx[hs_n % 64] <= wb_index;
            hs_n <= hs_n + 1;
        end
        if (wb_valid) wbv_cyc <= wbv_cyc + 1;
    end

    task automatic wr(input logic [7:0] a, input logic v);
        @(negedge clk);
        cache_addr = a;
        cache_din  = v;
        cache_we   = 1;
        @(negedge clk);
        cache_we   = 0;
    endtask

    task automatic rd(input logic [7:0] a, output logic v);
        @(negedge clk);
        cache_addr = a;
        cache_we   = 0;
        @(negedge clk);
        v = cache_dout;
    endtask

    task automatic clear_all;
        for (int i = 0; i < 256; i++) wr(i[7:0], 1'b0);
    endtask

    task automatic run_flush(output int busy, output int done_at);
        @(negedge clk) flush_req = 1;
        @(negedge clk) flush_req = 0;
        busy = 0;
        done_at = -1;
        while (flush_busy && busy < 3000) begin
            if (flush_done) done_at = busy;
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (flush_busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        resetn = 0;
        repeat (2) @(negedge clk);
        checks++; if (flush_busy !== 0) begin errors++; $display("FAIL reset_busy got=%b exp=0", flush_busy); end
        checks++; if (flush_done !== 0) begin errors++; $display("FAIL reset_done got=%b exp=0", flush_done); end
        checks++; if (wb_valid !== 0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_index !== 8'h00) begin errors++; $display("FAIL reset_wb_index got=%h exp=00", wb_index); end
        checks++; if (dut.state !== FLUSH_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, FLUSH_IDLE); end
        resetn = 1;
    endtask

    task automatic test_passthrough;
        logic v;
        @(negedge clk);
        cache_addr = 8'h05;
        cache_din  = 1;
        cache_we   = 1;
        #1;
        checks++; if (dr_we !== 1) begin errors++; $display("FAIL pass_we got=%b exp=1", dr_we); end
        checks++; if (dr_addr !== 8'h05) begin errors++; $display("FAIL pass_addr got=%h exp=05", dr_addr); end
        checks++; if (dr_din !== 1) begin errors++; $display("FAIL pass_din got=%b exp=1", dr_din); end
        @(negedge clk);
        cache_we = 0;
        @(negedge clk);
        checks++; if (cache_dout !== 1) begin errors++; $display("FAIL pass_read05 got=%b exp=1", cache_dout); end
        rd(8'h06, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL pass_read06 got=%b exp=0", v); end
        wr(8'h05, 1'b0);
    endtask

    task automatic test_clean_flush;
        int busy, done_at, w0;
        w0 = wbv_cyc;
        run_flush(busy, done_at);
        checks++; if (busy !== 513) begin errors++; $display("FAIL clean_busy_cycles got=%0d exp=513", busy); end
        checks++; if (done_at !== 512) begin errors++; $display("FAIL clean_done_cycle got=%0d exp=512", done_at); end
        checks++; if (wbv_cyc - w0 !== 0) begin errors++; $display("FAIL clean_wb_valid_cycles got=%0d exp=0", wbv_cyc - w0); end
    endtask

    task automatic test_sparse;
        int busy, done_at, h0, ones;
        logic v;
        logic [7:0] exp [3];
        exp[0] = 8'h00; exp[1] = 8'h7F; exp[2] = 8'hFF;
        for (int k = 0; k < 3; k++) wr(exp[k], 1'b1);
        wb_ready = 1;
        h0 = hs_n;
        run_flush(busy, done_at);
        checks++; if (busy !== 519) begin errors++; $display("FAIL sparse_busy_cycles got=%0d exp=519", busy); end
        checks++; if (hs_n - h0 !== 3) begin errors++; $display("FAIL sparse_handshakes got=%0d exp=3", hs_n - h0); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hs_idx[(h0 + k) % 64] !== exp[k]) begin
                errors++; $display("FAIL sparse_wb_index%0d got=%h exp=%h", k, hs_idx[(h0 + k) % 64], exp[k]);
            end
        end
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            rd(i[7:0], v);
            if (v !== 0) ones++;
        end
        checks++; if (ones !== 0) begin errors++; $display("FAIL sparse_bits_left got=%0d exp=0", ones); end
    endtask

    task automatic test_backpressure;
        int n, h0;
        logic v;
        wr(8'h10, 1'b1);
        wb_ready = 0;
        h0 = hs_n;
        @(negedge clk) flush_req = 1;
        @(negedge clk) flush_req = 0;
        n = 0;
        while (!wb_valid && n < 500) begin
            n++;
            @(negedge clk);
        end
        checks++; if (wb_valid !== 1) begin errors++; $display("FAIL bp_wb_valid_timeout got=%b exp=1", wb_valid); end
        for (int k = 0; k < 6; k++) begin
            if (k == 5) wb_ready = 1;
            checks++;
            if (wb_valid !== 1 || wb_index !== 8'h10) begin
                errors++; $display("FAIL bp_hold%0d got valid=%b index=%h exp valid=1 index=10", k, wb_valid, wb_index);
            end
            @(negedge clk);
        end
        checks++; if (wb_valid !== 0) begin errors++; $display("FAIL bp_valid_drop got=%b exp=0", wb_valid); end
        checks++; if (hs_n - h0 !== 1) begin errors++; $display("FAIL bp_handshakes got=%0d exp=1", hs_n - h0); end
        checks++; if (hs_idx[h0 % 64] !== 8'h10) begin errors++; $display("FAIL bp_hs_index got=%h exp=10", hs_idx[h0 % 64]); end
        wait_idle(n);
        checks++; if (flush_busy !== 0) begin errors++; $display("FAIL bp_end_timeout got=%b exp=0", flush_busy); end
        rd(8'h10, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL bp_bit10 got=%b exp=0", v); end
    endtask

    task automatic test_arbitration;
        int cnt, bad, done_at;
        logic v;
        wr(8'h30, 1'b1);
        wb_ready = 1;
        @(negedge clk) flush_req = 1;
        @(negedge clk) flush_req = 0;
        cnt = 0; bad = 0; done_at = -1;
        while (flush_busy && cnt < 3000) begin
            if (cnt == 10) begin
                cache_we = 1; cache_addr = 8'h20; cache_din = 1; flush_req = 1;
            end
            if (cnt == 11) flush_req = 0;
            if (cnt == 200) cache_we = 0;
            if (cache_dout !== 0) bad++;
            if (flush_done) done_at = cnt;
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt !== 515) begin errors++; $display("FAIL arb_busy_cycles got=%0d exp=515", cnt); end
        checks++; if (done_at !== 514) begin errors++; $display("FAIL arb_done_cycle got=%0d exp=514", done_at); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL arb_cache_dout_nonzero got=%0d exp=0", bad); end
        repeat (3) @(negedge clk);
        checks++; if (flush_busy !== 0) begin errors++; $display("FAIL arb_second_flush got=%b exp=0", flush_busy); end
        rd(8'h20, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL arb_bit20 got=%b exp=0", v); end
        rd(8'h30, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL arb_bit30 got=%b exp=0", v); end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk) flush_req = 1;
        n = 0;
        while (!flush_done && n < 3000) begin
            n++;
            @(negedge clk);
        end
        checks++; if (flush_done !== 1) begin errors++; $display("FAIL b2b_done_timeout got=%b exp=1", flush_done); end
        @(negedge clk);
        checks++; if (flush_busy !== 0) begin errors++; $display("FAIL b2b_idle_gap got=%b exp=0", flush_busy); end
        @(negedge clk);
        checks++; if (flush_busy !== 1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", flush_busy); end
        flush_req = 0;
        wait_idle(n);
        checks++; if (flush_busy !== 0) begin errors++; $display("FAIL b2b_end_timeout got=%b exp=0", flush_busy); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic v;
        wr(8'h03, 1'b1);
        wr(8'h90, 1'b1);
        wb_ready = 0;
        @(negedge clk) flush_req = 1;
        @(negedge clk) flush_req = 0;
        n = 0;
        while (!wb_valid && n < 1000) begin n++; @(negedge clk); end
        checks++; if (wb_valid !== 1 || wb_index !== 8'h03) begin errors++; $display("FAIL mid_first_wb got valid=%b index=%h exp valid=1 index=03", wb_valid, wb_index); end
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;
        n = 0;
        while (!wb_valid && n < 1000) begin n++; @(negedge clk); end
        checks++; if (wb_valid !== 1 || wb_index !== 8'h90) begin errors++; $display("FAIL mid_second_wb got valid=%b index=%h exp valid=1 index=90", wb_valid, wb_index); end
        cache_addr = 8'h55;
        resetn = 0;
        #1;
        checks++; if (wb_valid !== 0) begin errors++; $display("FAIL mid_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (flush_busy !== 0) begin errors++; $display("FAIL mid_busy got=%b exp=0", flush_busy); end
        checks++; if (dut.state !== FLUSH_IDLE) begin errors++; $display("FAIL mid_state got=%0d exp=%0d", dut.state, FLUSH_IDLE); end
        checks++; if (dr_addr !== 8'h55) begin errors++; $display("FAIL mid_passthrough got=%h exp=55", dr_addr); end
        @(negedge clk);
        resetn = 1;
        wb_ready = 1;
        rd(8'h03, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL mid_bit03 got=%b exp=0", v); end
        rd(8'h90, v);
        checks++; if (v !== 1) begin errors++; $display("FAIL mid_bit90 got=%b exp=1", v); end
    endtask

    initial begin
        test_reset;
        clear_all;
        test_passthrough;
        test_clean_flush;
        test_sparse;
        test_backpressure;
        test_arbitration;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
